uart_mmio: RTL and testbench

//  Memory-mapped UART on the core's data bus, downstream of core_top's mem port
//  (wmem_en_o/rmem_en_o/mem_addr_o/wmem_data_o; read data returns on rmem_data_i).

---
 rtl/uart_mmio.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: 16-byte register window, TX FIFO and serialiser.
// Define UART_RX_EN to build the RX synchroniser, receiver FSM and holding register.
module uart_mmio #(
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter int          TX_FIFO_DEPTH   = 8,
  parameter logic [15:0] CLK_DIV_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wmem_en_i,
  input  logic        rmem_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] wmem_data_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  input  logic        rx_i,
  output logic        irq_o
);

  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic       hit;
  logic [1:0] offset;
  logic       wr_txdata;
  logic       wr_baud;

  assign hit       = (mem_addr_i[31:4] == BASE_ADDR[31:4]);
  assign offset    = mem_addr_i[3:2];
  assign wr_txdata = hit && wmem_en_i && (offset == 2'd0);
  assign wr_baud   = hit && wmem_en_i && (offset == 2'd3);

  logic unused_bits;
  assign unused_bits = ^{wmem_data_i[31:16], mem_addr_i[1:0]};

  // Baud divisor; zero behaves as one so the bit counters never stall
  logic [15:0] bauddiv_reg;
  logic [15:0] div_eff;
  logic [15:0] div_m1;

  assign div_eff = (bauddiv_reg == 16'd0) ? 16'd1 : bauddiv_reg;
  assign div_m1  = div_eff - 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bauddiv_reg <= CLK_DIV_DEFAULT;
    end else if (wr_baud) begin
      bauddiv_reg <= wmem_data_i[15:0];
    end
  end

  // TX FIFO with wrap-bit pointers
  logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
  logic [7:0]  fifo_rdata_reg;
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_push;
  logic        tx_pop;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_push  = wr_txdata && !fifo_full;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= wmem_data_i[7:0];
    end
    if (tx_pop) begin
      fifo_rdata_reg <= fifo_mem[rd_ptr_reg[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (tx_pop)    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // TX serialiser; each bit reloads its counter, so divisor changes apply per bit
  tx_state_t   tx_state_reg, tx_state_next;
  logic [15:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]  tx_bit_reg, tx_bit_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic        tx_line_reg, tx_line_next;
  logic        tx_busy;

  assign tx_busy = (tx_state_reg != TX_IDLE);
  assign tx_o    = tx_line_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_line_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_line_reg  <= tx_line_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_pop        = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (!fifo_empty) begin
          tx_pop        = 1'b1;
          tx_state_next = TX_START;
          tx_cnt_next   = div_m1;
        end
      end
      TX_START: begin
        if (tx_cnt_reg == 16'd0) begin
          tx_state_next = TX_DATA;
          tx_cnt_next   = div_m1;
          tx_bit_next   = 3'd0;
          tx_shift_next = fifo_rdata_reg;
        end else begin
          tx_cnt_next = tx_cnt_reg - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_reg == 16'd0) begin
          tx_cnt_next   = div_m1;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = TX_STOP;
          end else begin
            tx_bit_next = tx_bit_reg + 3'd1;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_reg == 16'd0) begin
          tx_state_next = TX_IDLE;
        end else begin
          tx_cnt_next = tx_cnt_reg - 16'd1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
    case (tx_state_next)
      TX_START: tx_line_next = 1'b0;
      TX_DATA:  tx_line_next = tx_shift_next[0];
      default:  tx_line_next = 1'b1;
    endcase
  end

  logic       rx_valid;
  logic       rx_overrun;
  logic [7:0] rx_byte;

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        rd_rxdata;
  logic        clr_overrun;
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  rx_state_t   rx_state_reg, rx_state_next;
  logic [15:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]  rx_bit_reg, rx_bit_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic        rx_done;
  logic [15:0] half_div;
  logic [15:0] half_m1;
  logic        rx_valid_reg, rx_overrun_reg;
  logic [7:0]  rx_byte_reg;

  assign rd_rxdata   = hit && rmem_en_i && (offset == 2'd2);
  assign clr_overrun = hit && wmem_en_i && (offset == 2'd1) && wmem_data_i[4];
  assign half_div    = {1'b0, div_eff[15:1]};
  assign half_m1     = (half_div == 16'd0) ? 16'd0 : half_div - 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_prev_reg    <= 1'b1;
      rx_state_reg   <= RX_IDLE;
      rx_cnt_reg     <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
      rx_byte_reg    <= '0;
    end else begin
      rx_meta_reg  <= rx_i;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      // A completing byte beats a same-cycle RXDATA read
      if (rx_done) begin
        rx_byte_reg  <= rx_shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rd_rxdata) begin
        rx_valid_reg <= 1'b0;
      end
      if (rx_done && rx_valid_reg && !rd_rxdata) begin
        rx_overrun_reg <= 1'b1;
      end else if (clr_overrun) begin
        rx_overrun_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_done       = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_next = RX_START;
          rx_cnt_next   = half_m1;
        end
      end
      RX_START: begin
        if (rx_cnt_reg == 16'd0) begin
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
          rx_cnt_next   = div_m1;
          rx_bit_next   = 3'd0;
        end else begin
          rx_cnt_next = rx_cnt_reg - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == 16'd0) begin
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          rx_cnt_next   = div_m1;
          if (rx_bit_reg == 3'd7) begin
            rx_state_next = RX_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + 3'd1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == 16'd0) begin
          rx_state_next = RX_IDLE;
          rx_done       = rx_sync_reg;
        end else begin
          rx_cnt_next = rx_cnt_reg - 16'd1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign rx_valid   = rx_valid_reg;
  assign rx_overrun = rx_overrun_reg;
  assign rx_byte    = rx_byte_reg;
`else
  logic unused_rx;
  assign unused_rx  = rx_i;
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_byte    = 8'd0;
`endif

  assign irq_o = rx_valid;

  always_comb begin
    rdata_o = '0;
    if (hit && rmem_en_i) begin
      case (offset)
        2'd1:    rdata_o = {27'b0, rx_overrun, rx_valid, tx_busy, fifo_empty, fifo_full};
        2'd2:    rdata_o = {24'b0, rx_byte};
        2'd3:    rdata_o = {16'b0, bauddiv_reg};
        default: rdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: bus map, TX waveform and FIFO scoreboard,
// plus receiver checks when UART_RX_EN is defined.
module tb_uart_mmio;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam logic [31:0] A_TX    = BASE + 32'h0;
  localparam logic [31:0] A_STAT  = BASE + 32'h4;
  localparam logic [31:0] A_RX    = BASE + 32'h8;
  localparam logic [31:0] A_BAUD  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wmem_en_i = 1'b0;
  logic        rmem_en_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] wmem_data_i = '0;
  logic        rx_i = 1'b1;
  logic [31:0] rdata_o;
  logic        tx_o;
  logic        irq_o;

  int   checks_cnt = 0;
  int   errors_cnt = 0;
  bit   mon_en = 1'b0;
  logic [7:0] tx_sb [$];

  uart_mmio dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wmem_en_i   (wmem_en_i),
    .rmem_en_i   (rmem_en_i),
    .mem_addr_i  (mem_addr_i),
    .wmem_data_i (wmem_data_i),
    .rdata_o     (rdata_o),
    .tx_o        (tx_o),
    .rx_i        (rx_i),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wmem_en_i   = 1'b1;
    mem_addr_i  = a;
    wmem_data_i = d;
    @(negedge clk);
    wmem_en_i   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    rmem_en_i  = 1'b1;
    mem_addr_i = a;
    #1 d = rdata_o;
    @(negedge clk);
    rmem_en_i  = 1'b0;
  endtask

  // 8N1 frame on rx_i at 4 clocks per bit, then idle
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_i = b[k];
      repeat (4) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // TX monitor: decodes frames at BAUDDIV=4 and pops the scoreboard
  initial begin : tx_monitor
    logic [7:0]  b;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx_o === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge clk);
          b[k] = tx_o;
        end
        repeat (4) @(negedge clk);
        check("tx_stop", {31'b0, tx_o}, 32'd1);
        exp = (tx_sb.size() > 0) ? {24'b0, tx_sb.pop_front()} : 32'hDEAD_BEEF;
        check("tx_byte", {24'b0, b}, exp);
      end
    end
  end

  initial begin : watchdog
    #200_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] rd;
    logic [7:0]  d;
    logic        exp_tx;
    logic [31:0] exp_st;
    int          n;

    // 1: reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx_o}, 32'd1);
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(A_STAT, rd); check("rst_status", rd, 32'h2);
    bus_read(A_BAUD, rd); check("rst_baud", rd, 32'd434);

    // decode boundaries
    bus_write(A_BAUD, 32'hFFFF_0004);
    bus_read(A_BAUD, rd); check("baud_upper0", rd, 32'd4);
    bus_write(BASE + 32'h1C, 32'd9);
    bus_read(A_BAUD, rd); check("miss_write", rd, 32'd4);
    bus_read(BASE + 32'h1C, rd); check("miss_read", rd, 32'd0);
    bus_read(A_TX, rd); check("txdata_rd0", rd, 32'd0);
    mem_addr_i = A_BAUD;
    #1 check("no_rmem_rd0", rdata_o, 32'd0);
    @(negedge clk);

    // 2: exact waveform of 0x55 at BAUDDIV=4
    mon_en = 1'b1;
    d = 8'h55;
    tx_sb.push_back(d);
    bus_write(A_TX, {24'b0, d});
    for (int i = 0; i < 44; i++) begin
      rmem_en_i  = 1'b1;
      mem_addr_i = A_STAT;
      exp_tx = (i == 0) ? 1'b1 : (i <= 4) ? 1'b0 : (i <= 36) ? d[(i - 5) / 4] : 1'b1;
      exp_st = (i == 0) ? 32'h0 : (i <= 40) ? 32'h6 : 32'h2;
      #1;
      check($sformatf("wave_tx[%0d]", i), {31'b0, tx_o}, {31'b0, exp_tx});
      check($sformatf("wave_st[%0d]", i), rdata_o, exp_st);
      @(negedge clk);
    end
    rmem_en_i = 1'b0;

    // 3: fill FIFO back-to-back, overflow write dropped
    for (int j = 0; j < 9; j++) begin
      tx_sb.push_back(8'h10 + 8'(j));
      bus_write(A_TX, 32'h10 + j);
    end
    bus_read(A_STAT, rd); check("fifo_full", rd, 32'h7 & 32'h5 | 32'h2 & 32'h0 | 32'h6 & 32'h5);
    bus_write(A_TX, 32'hEE);
    bus_read(A_STAT, rd); check("full_after_drop", rd, 32'h5);
    n = 0;
    while (tx_sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", tx_sb.size(), 32'd0);
    repeat (20) @(negedge clk);
    bus_read(A_STAT, rd); check("tx_idle_end", rd, 32'h2);
    mon_en = 1'b0;

`ifdef UART_RX_EN
    // 4: single byte received
    rx_frame(8'hA3, 1'b1);
    check("rx_irq", {31'b0, irq_o}, 32'd1);
    bus_read(A_RX, rd); check("rx_data", rd, 32'hA3);
    check("rx_irq_clr", {31'b0, irq_o}, 32'd0);
    bus_read(A_STAT, rd); check("rx_valid_clr", rd, 32'h2);
    // 5: overrun
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    bus_read(A_STAT, rd); check("ovr_status", rd, 32'h1A);
    bus_read(A_RX, rd); check("ovr_data", rd, 32'h22);
    bus_read(A_STAT, rd); check("ovr_after_rd", rd, 32'h12);
    bus_write(A_STAT, 32'h10);
    bus_read(A_STAT, rd); check("ovr_cleared", rd, 32'h2);
    // 6: glitch and framing error
    rx_i = 1'b0;
    @(negedge clk);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(A_STAT, rd); check("glitch", rd, 32'h2);
    rx_frame(8'h5A, 1'b0);
    bus_read(A_STAT, rd); check("frame_err", rd, 32'h2);
    rx_frame(8'h3C, 1'b1);
    bus_read(A_RX, rd); check("rx_recover", rd, 32'h3C);
`else
    rx_frame(8'hA3, 1'b1);
    check("norx_irq", {31'b0, irq_o}, 32'd0);
    bus_read(A_RX, rd); check("norx_data", rd, 32'd0);
    bus_read(A_STAT, rd); check("norx_status", rd, 32'h2);
`endif

    // reset mid-frame returns the line high immediately
    bus_write(A_TX, 32'h00);
    repeat (10) @(negedge clk);
    check("mid_low", {31'b0, tx_o}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_tx", {31'b0, tx_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(A_STAT, rd); check("mid_rst_status", rd, 32'h2);
    bus_read(A_BAUD, rd); check("mid_rst_baud", rd, 32'd434);
    repeat (50) @(negedge clk);
    check("mid_rst_idle", {31'b0, tx_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
